vram_arbiter: RTL
=================

Name: vram_arbiter

Overview:
- Shares one synchronous single-port video SRAM between the VGA scan-out path and the 6502 bus.
- Framebuffer is 400x300 at 4 bpp, packed 2 pixels per byte, so each line is 200 bytes and the frame is 60000 bytes.
- Consumes the pix/line/visible outputs of the VGA counters, fetches pixel bytes ahead of the beam, and drives color.
- Grants every remaining memory cycle to the CPU through a req/ack handshake.

Parameters:
- ADDR_W, 16, VRAM address width.
- LINE_BYTES, 200, bytes per framebuffer line.
- V_LINES, 300, framebuffer lines (compared against the halved line input).
- FETCH_FIRST, 6, first pix value on which a video fetch is issued.
- FETCH_LAST, 404, last pix value on which a video fetch is issued.

Ports:
- clk  in  1  pixel clock, 20 MHz; all logic on the rising edge; one clock domain.
- reset  in  1  synchronous, active-high.
- pix  in  9  horizontal counter from the VGA counters.
- line  in  9  halved line counter, 0..313.
- visible  in  1  beam is in the active area.
- color  out  4  pixel colour index.
- mem_addr  out  ADDR_W  SRAM address.
- mem_wdata  out  8  SRAM write data.
- mem_we  out  1  SRAM write enable.
- mem_rdata  in  8  SRAM read data, valid the cycle after its address.
- cpu_req  in  1  CPU access request; held with addr/we/wdata until ack.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  CPU VRAM address.
- cpu_wdata  in  8  CPU write data.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_rdata  out  8  read data; valid with ack, held until the next read ack.

Behaviour:
- Video slot: vslot = (line < V_LINES) && pix[0]==0 && FETCH_FIRST <= pix <= FETCH_LAST.
  - In a vslot: mem_addr = line_base + ((pix - FETCH_FIRST) >> 1), mem_we = 0.
  - line_base = line * LINE_BYTES. It is a registered value, recomputed whenever line changes, and stable before pix reaches FETCH_FIRST.
  - The video path always wins its slot; the CPU is never granted in a vslot.
- Video data:
  - A fetch issued at pix f returns mem_rdata at f+1, which is latched into pix_byte at the end of f+1.
  - Pixels x = f-6 (high nibble) and x = f-5 (low nibble) display at pix f+2 and f+3.
  - color = visible ? (pix[0] ? pix_byte[3:0] : pix_byte[7:4]) : 0. This is combinational from pix_byte, pix and visible.
  - The first visible pixel is at pix 8; pix_byte is therefore loaded from byte 0 of the line.
- CPU state machine, states IDLE, CAPT, ACK:
  - IDLE: if cpu_req && !vslot, drive mem_addr = cpu_addr, mem_we = cpu_we, mem_wdata = cpu_wdata for this cycle (grant cycle G), then go to CAPT. Otherwise stay in IDLE with mem_we = 0.
  - CAPT (G+1): CPU does not use the memory; a vslot may. Latch mem_rdata into cpu_rdata if the access was a read. Go to ACK.
  - ACK (G+2): cpu_ack = 1; cpu_req is ignored. Go to IDLE.
  - Latency: 3 cycles from grant to ack. Worst-case wait before grant is 1 cycle during fetch windows.
  - A request still asserted at G+3 is treated as a new request.
- mem_we is 1 only in a CPU write grant cycle. In any cycle with no grant and no vslot: mem_addr = cpu_addr, mem_we = 0.
- Address range: CPU addresses are passed through unchecked (the full 64 KiB space); the video path never exceeds 59999.
- Outside line < V_LINES, or outside the fetch window, every cycle is available to the CPU.
- Reset:
  - State goes to IDLE; cpu_ack = 0, cpu_rdata = 0, pix_byte = 0, line_base = 0, mem_we = 0; color = 0 because visible is gated.
  - Reset asserted in CAPT or ACK aborts the access: no ack is issued, and a write already issued at G stays committed.
- Simultaneous events: cpu_req rising on a vslot is deferred to the next cycle (odd pix).

Test Plan:
- Fill VRAM with byte k = k[7:0], then run one line with line=0 -> fetch addresses 0..199 on even pix 6..404; color at pix 8,9 = 0x0,0x0; at pix 10,11 = 0x0,0x1.
- line=5 -> first fetch address 1000; line=299 -> last fetch address 59999; line=300 -> no vslot, all cycles available to the CPU.
- CPU read of 0x1234 (contents 0xA5) issued at odd pix 101 -> mem_addr 0x1234 at pix 101; cpu_ack at pix 103; cpu_rdata = 0xA5; the video fetch at pix 102 is unaffected.
- CPU write of 0x5A to 100 with req raised at pix 10 (vslot) -> grant at pix 11 with mem_we=1 only there; ack at pix 13; a later video fetch of byte 100 shows color nibbles 5, A.
- Back-to-back CPU requests with req held through ack -> second grant at G+3 or G+4 depending on vslot; exactly one ack per access.
- Reset asserted in CAPT -> no cpu_ack; state IDLE; cpu_rdata = 0; the next request completes normally in 3 cycles.

Source files
------------

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one single-port video SRAM between VGA scan-out and the CPU.
// Video fetches own every even pix in the fetch window on framebuffer lines;
// the CPU gets all other cycles through a three-cycle req/ack handshake.
module vram_arbiter #(
   parameter int unsigned ADDR_W      = 16,
   parameter int unsigned LINE_BYTES  = 200,
   parameter int unsigned V_LINES     = 300,
   parameter int unsigned FETCH_FIRST = 6,
   parameter int unsigned FETCH_LAST  = 404
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [8:0]        pix,
   input  logic [8:0]        line,
   input  logic              visible,
   output logic [3:0]        color,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   output logic              mem_we,
   input  logic [7:0]        mem_rdata,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [7:0]        cpu_wdata,
   output logic              cpu_ack,
   output logic [7:0]        cpu_rdata
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CAPT = 2'd1,
      ACK  = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   line_base_q;
   logic [7:0]          pix_byte_q;
   logic                vslot_q;
   logic                cpu_we_q;
   logic                cpu_ack_q;
   logic [7:0]          cpu_rdata_q;
   logic                vslot_c;
   logic                grant_c;
   logic [ADDR_W-1:0]   video_addr_c;

   // Video slot decode and fetch address for the current beam position.
   always_comb begin
      vslot_c      = (line < 9'(V_LINES)) && !pix[0] &&
                     (pix >= 9'(FETCH_FIRST)) && (pix <= 9'(FETCH_LAST));
      video_addr_c = line_base_q + ADDR_W'((pix - 9'(FETCH_FIRST)) >> 1);
   end

   // CPU handshake next-state and SRAM port mux; video always wins its slot.
   always_comb begin
      state_d   = state_q;
      grant_c   = 1'b0;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_we    = 1'b0;
      if (vslot_c) begin
         mem_addr = video_addr_c;
      end
      case (state_q)
         IDLE: begin
            if (cpu_req && !vslot_c && !reset) begin
               grant_c = 1'b1;
               mem_we  = cpu_we;
               state_d = CAPT;
            end
         end
         CAPT:    state_d = ACK;
         ACK:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State, handshake and video data registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         line_base_q <= '0;
         pix_byte_q  <= '0;
         vslot_q     <= 1'b0;
         cpu_we_q    <= 1'b0;
         cpu_ack_q   <= 1'b0;
         cpu_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         line_base_q <= ADDR_W'(line) * ADDR_W'(LINE_BYTES);
         vslot_q     <= vslot_c;
         cpu_ack_q   <= (state_q == CAPT);
         if (vslot_q) begin
            pix_byte_q <= mem_rdata;
         end
         if (grant_c) begin
            cpu_we_q <= cpu_we;
         end
         if ((state_q == CAPT) && !cpu_we_q) begin
            cpu_rdata_q <= mem_rdata;
         end
      end
   end

   // Even pix shows the high nibble, odd pix the low nibble.
   always_comb begin
      color = visible ? (pix[0] ? pix_byte_q[3:0] : pix_byte_q[7:4]) : 4'h0;
   end

   assign cpu_ack   = cpu_ack_q;
   assign cpu_rdata = cpu_rdata_q;

endmodule
